alu_system_ctrl: RTL and testbench

//  Hardwired control unit driving every select/function/enable input of ALU_System.

---
 rtl/alu_system_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_alu_system_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_system_ctrl.sv
// alu_system_ctrl: hardwired sequencer for ALU_System.
// Two-byte fetch into IR, one or two execute cycles, Moore outputs.
module alu_system_ctrl #(
    parameter bit CLR_RF = 1'b1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IR_out,
    input  logic [3:0]  ALU_ZCNO,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_TSel,
    output logic [3:0]  RF_RSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutASel,
    output logic [1:0]  ARF_OutBSel,
    output logic [1:0]  ARF_FunSel,
    output logic [3:0]  ARF_RSel,
    output logic [1:0]  IR_Funsel,
    output logic        IR_Enable,
    output logic        IR_LH,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic        Halted
);
    typedef enum logic [2:0] {
        S_CLR,
        S_F0,
        S_F1,
        S_EX0,
        S_EX1,
        S_HALT
    } state_t;

    localparam logic [1:0] FS_DEC  = 2'b00;
    localparam logic [1:0] FS_INC  = 2'b01;
    localparam logic [1:0] FS_LOAD = 2'b10;
    localparam logic [1:0] FS_CLR  = 2'b11;

    localparam logic [1:0] ARF_AR = 2'b00;
    localparam logic [1:0] ARF_PC = 2'b10;

    localparam logic [3:0] SEL_PC = 4'b1000;
    localparam logic [3:0] SEL_AR = 4'b0100;

    localparam logic [3:0] ALU_A   = 4'b0000;
    localparam logic [3:0] ALU_B   = 4'b0001;
    localparam logic [3:0] ALU_NOT = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0111;
    localparam logic [3:0] ALU_OR  = 4'b1000;

    localparam logic [3:0] OP_LDI  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_MOV  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_INC  = 4'h9;
    localparam logic [3:0] OP_DEC  = 4'hA;
    localparam logic [3:0] OP_BRA  = 4'hB;
    localparam logic [3:0] OP_BNE  = 4'hC;
    localparam logic [3:0] OP_BEQ  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;

    state_t     state;
    state_t     state_nx;
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [3:0] rd_hot;
    logic       z;
    logic       unused_bits;

    assign op     = IR_out[15:12];
    assign rd     = IR_out[11:10];
    assign rs     = IR_out[9:8];
    assign rd_hot = 4'b1000 >> rd;
    assign z      = ALU_ZCNO[3];

    // immediate is routed through the datapath muxes; only Z steers control
    assign unused_bits = ^{IR_out[7:0], ALU_ZCNO[2:0]};

    always_ff @(posedge Clock) begin
        if (Reset) state <= S_CLR;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;
        RF_OutASel  = 3'd0;
        RF_OutBSel  = 3'd0;
        RF_FunSel   = FS_LOAD;
        RF_TSel     = 4'b0000;
        RF_RSel     = 4'b0000;
        ALU_FunSel  = ALU_A;
        ARF_OutASel = 2'b00;
        ARF_OutBSel = 2'b00;
        ARF_FunSel  = FS_LOAD;
        ARF_RSel    = 4'b0000;
        IR_Funsel   = FS_LOAD;
        IR_Enable   = 1'b0;
        IR_LH       = 1'b0;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        Halted      = 1'b0;
        unique case (state)
            S_CLR: begin
                ARF_FunSel = FS_CLR;
                ARF_RSel   = 4'b1110;
                IR_Funsel  = FS_CLR;
                IR_Enable  = 1'b1;
                RF_FunSel  = FS_CLR;
                RF_RSel    = CLR_RF ? 4'b1111 : 4'b0000;
                state_nx   = S_F0;
            end
            S_F0, S_F1: begin
                ARF_OutBSel = ARF_PC;
                Mem_CS      = 1'b0;
                IR_Enable   = 1'b1;
                IR_LH       = (state == S_F1);
                ARF_FunSel  = FS_INC;
                ARF_RSel    = SEL_PC;
                state_nx    = (state == S_F0) ? S_F1 : S_EX0;
            end
            S_EX0: begin
                state_nx = S_F0;
                unique case (op)
                    OP_LDI: begin
                        MuxASel = 2'b10;
                        RF_RSel = rd_hot;
                    end
                    OP_LD, OP_ST: begin
                        MuxBSel  = 2'b10;
                        ARF_RSel = SEL_AR;
                        state_nx = S_EX1;
                    end
                    OP_MOV: begin
                        RF_OutASel = {1'b0, rs};
                        ALU_FunSel = ALU_A;
                        RF_RSel    = rd_hot;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        RF_OutASel = {1'b0, rd};
                        RF_OutBSel = {1'b0, rs};
                        RF_RSel    = rd_hot;
                        unique case (op[1:0])
                            2'b00:   ALU_FunSel = ALU_ADD;
                            2'b01:   ALU_FunSel = ALU_SUB;
                            2'b10:   ALU_FunSel = ALU_AND;
                            default: ALU_FunSel = ALU_OR;
                        endcase
                    end
                    OP_NOT: begin
                        RF_OutASel = {1'b0, rs};
                        ALU_FunSel = ALU_NOT;
                        RF_RSel    = rd_hot;
                    end
                    OP_INC: begin
                        RF_FunSel = FS_INC;
                        RF_RSel   = rd_hot;
                    end
                    OP_DEC: begin
                        RF_FunSel = FS_DEC;
                        RF_RSel   = rd_hot;
                    end
                    OP_BRA: begin
                        MuxBSel  = 2'b10;
                        ARF_RSel = SEL_PC;
                    end
                    OP_BNE: begin
                        MuxBSel = 2'b10;
                        if (!z) ARF_RSel = SEL_PC;
                    end
                    OP_BEQ: begin
                        MuxBSel = 2'b10;
                        if (z) ARF_RSel = SEL_PC;
                    end
                    OP_HALT: state_nx = S_HALT;
                    default: ;
                endcase
            end
            S_EX1: begin
                state_nx    = S_F0;
                ARF_OutBSel = ARF_AR;
                Mem_CS      = 1'b0;
                if (op == OP_ST) begin
                    Mem_WR     = 1'b1;
                    RF_OutBSel = {1'b0, rd};
                    ALU_FunSel = ALU_B;
                end else begin
                    MuxASel = 2'b01;
                    RF_RSel = rd_hot;
                end
            end
            S_HALT: Halted = 1'b1;
            default: state_nx = S_CLR;
        endcase
    end

endmodule

// File: tb/tb_alu_system_ctrl.sv
// tb_alu_system_ctrl: controller drives a behavioural datapath whose state
// is compared against an instruction-level model of the ISA.
module tb_alu_system_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] ir_out;
    logic [3:0]  alu_zcno;
    logic [1:0]  mux_a_sel;
    logic [1:0]  mux_b_sel;
    logic        mux_c_sel;
    logic [2:0]  rf_out_a_sel;
    logic [2:0]  rf_out_b_sel;
    logic [1:0]  rf_fun_sel;
    logic [3:0]  rf_t_sel;
    logic [3:0]  rf_r_sel;
    logic [3:0]  alu_fun_sel;
    logic [1:0]  arf_out_a_sel;
    logic [1:0]  arf_out_b_sel;
    logic [1:0]  arf_fun_sel;
    logic [3:0]  arf_r_sel;
    logic [1:0]  ir_fun_sel;
    logic        ir_enable;
    logic        ir_lh;
    logic        mem_wr;
    logic        mem_cs;
    logic        halted;

    alu_system_ctrl #(.CLR_RF(1'b1)) dut (
        .Clock(clk),
        .Reset(reset),
        .IR_out(ir_out),
        .ALU_ZCNO(alu_zcno),
        .MuxASel(mux_a_sel),
        .MuxBSel(mux_b_sel),
        .MuxCSel(mux_c_sel),
        .RF_OutASel(rf_out_a_sel),
        .RF_OutBSel(rf_out_b_sel),
        .RF_FunSel(rf_fun_sel),
        .RF_TSel(rf_t_sel),
        .RF_RSel(rf_r_sel),
        .ALU_FunSel(alu_fun_sel),
        .ARF_OutASel(arf_out_a_sel),
        .ARF_OutBSel(arf_out_b_sel),
        .ARF_FunSel(arf_fun_sel),
        .ARF_RSel(arf_r_sel),
        .IR_Funsel(ir_fun_sel),
        .IR_Enable(ir_enable),
        .IR_LH(ir_lh),
        .Mem_WR(mem_wr),
        .Mem_CS(mem_cs),
        .Halted(halted)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // behavioural ALU_System datapath
    logic [7:0]  p_r [4];
    logic [7:0]  p_pc;
    logic [7:0]  p_ar;
    logic [7:0]  p_sp;
    logic [15:0] p_ir;
    logic [7:0]  p_mem [256];
    logic        poke_en;
    logic [7:0]  poke_addr;
    logic [7:0]  poke_data;
    logic [7:0]  rf_a, rf_b, arf_a, arf_b;
    logic [7:0]  alu_a, alu_y, mem_q, mux_a, mux_b;

    assign ir_out = p_ir;

    function automatic logic [7:0] arf_pick(input logic [1:0] s);
        case (s)
            2'b00:   return p_ar;
            2'b01:   return p_sp;
            default: return p_pc;
        endcase
    endfunction

    function automatic logic [7:0] fun(input logic [1:0] f,
                                       input logic [7:0] cur,
                                       input logic [7:0] d);
        case (f)
            2'b00:   return cur - 8'd1;
            2'b01:   return cur + 8'd1;
            2'b10:   return d;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        rf_a  = rf_out_a_sel[2] ? 8'h00 : p_r[rf_out_a_sel[1:0]];
        rf_b  = rf_out_b_sel[2] ? 8'h00 : p_r[rf_out_b_sel[1:0]];
        arf_a = arf_pick(arf_out_a_sel);
        arf_b = arf_pick(arf_out_b_sel);
        mem_q = p_mem[arf_b];
        alu_a = mux_c_sel ? arf_a : rf_a;
        case (alu_fun_sel)
            4'h0:    alu_y = alu_a;
            4'h1:    alu_y = rf_b;
            4'h2:    alu_y = ~alu_a;
            4'h4:    alu_y = alu_a + rf_b;
            4'h6:    alu_y = alu_a - rf_b;
            4'h7:    alu_y = alu_a & rf_b;
            4'h8:    alu_y = alu_a | rf_b;
            default: alu_y = 8'h00;
        endcase
        case (mux_a_sel)
            2'b01:   mux_a = mem_q;
            2'b10:   mux_a = p_ir[7:0];
            default: mux_a = alu_y;
        endcase
        case (mux_b_sel)
            2'b01:   mux_b = mem_q;
            2'b10:   mux_b = p_ir[7:0];
            default: mux_b = alu_y;
        endcase
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (rf_r_sel[3 - i]) p_r[i] <= fun(rf_fun_sel, p_r[i], mux_a);
        if (arf_r_sel[3]) p_pc <= fun(arf_fun_sel, p_pc, mux_b);
        if (arf_r_sel[2]) p_ar <= fun(arf_fun_sel, p_ar, mux_b);
        if (arf_r_sel[1]) p_sp <= fun(arf_fun_sel, p_sp, mux_b);
        if (ir_enable) begin
            case (ir_fun_sel)
                2'b11: p_ir <= 16'h0000;
                2'b10: if (ir_lh) p_ir[15:8] <= mem_q;
                       else       p_ir[7:0]  <= mem_q;
                2'b01: p_ir <= p_ir + 16'd1;
                default: p_ir <= p_ir - 16'd1;
            endcase
        end
        if (!mem_cs && mem_wr) p_mem[arf_b] <= alu_y;
        if (poke_en) p_mem[poke_addr] <= poke_data;
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    function automatic logic is_f0();
        return ir_enable && !ir_lh && ir_fun_sel == 2'b10 &&
               arf_out_b_sel == 2'b10 && arf_r_sel == 4'b1000 && !halted;
    endfunction

    // ISA-level reference state
    logic [7:0] m_r [4];
    logic [7:0] m_pc;
    logic [7:0] m_ar;
    logic [7:0] m_mem [256];
    logic [3:0] alu_tab [4];

    initial begin : main
        logic [15:0] ins;
        logic [3:0]  op;
        logic [1:0]  rd, rs;
        logic [7:0]  imm;
        logic [3:0]  hot;
        logic        z, taken, stop;

        reset     = 1'b1;
        alu_zcno  = 4'h0;
        poke_en   = 1'b0;
        poke_addr = 8'h00;
        poke_data = 8'h00;
        alu_tab   = '{4'h4, 4'h6, 4'h7, 4'h8};

        for (int a = 0; a < 256; a++) begin
            m_mem[a] = 8'($urandom);
            if (m_mem[a][7:4] == 4'hE) m_mem[a][7:4] = 4'hF;
        end
        // LDI R1,2A; ADD R2,R1; LD R1,[55]; BNE 10 (Z=1); BNE 10 (Z=0)
        m_mem[0] = 8'h2A; m_mem[1] = 8'h00;
        m_mem[2] = 8'h00; m_mem[3] = 8'h44;
        m_mem[4] = 8'h55; m_mem[5] = 8'h10;
        m_mem[6] = 8'h10; m_mem[7] = 8'hC0;
        m_mem[8] = 8'h10; m_mem[9] = 8'hC0;

        @(negedge clk);
        for (int a = 0; a < 256; a++) poke(8'(a), m_mem[a]);
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_pc = 8'h00;
        m_ar = 8'h00;

        reset = 1'b0;
        check("clr_arf_fun", 16'(arf_fun_sel), 16'h3);
        check("clr_arf_rsel", 16'(arf_r_sel), 16'hE);
        check("clr_ir_fun", 16'(ir_fun_sel), 16'h3);
        check("clr_ir_en", 16'(ir_enable), 16'h1);
        check("clr_rf_fun", 16'(rf_fun_sel), 16'h3);
        check("clr_rf_rsel", 16'(rf_r_sel), 16'hF);
        check("clr_mem_cs", 16'(mem_cs), 16'h1);
        check("clr_halted", 16'(halted), 16'h0);
        @(negedge clk);

        stop = 1'b0;
        for (int k = 0; k < 400 && !stop; k++) begin
            check("f0_state", 16'(is_f0()), 16'h1);
            if (!is_f0()) break;
            for (int i = 0; i < 4; i++)
                check($sformatf("r%0d", i + 1), 16'(p_r[i]), 16'(m_r[i]));
            check("pc", 16'(p_pc), 16'(m_pc));
            check("ar", 16'(p_ar), 16'(m_ar));

            ins = {m_mem[8'(m_pc + 8'd1)], m_mem[m_pc]};
            op  = ins[15:12];
            rd  = ins[11:10];
            rs  = ins[9:8];
            imm = ins[7:0];
            hot = 4'b1000 >> rd;
            z   = (k == 3) ? 1'b1 : (k == 4) ? 1'b0 : 1'($urandom);
            alu_zcno = {z, 3'($urandom)};
            taken = (op == 4'hB) || (op == 4'hC && !z) || (op == 4'hD && z);

            m_pc = m_pc + 8'd2;
            case (op)
                4'h0: m_r[rd] = imm;
                4'h1: begin m_ar = imm; m_r[rd] = m_mem[imm]; end
                4'h2: begin m_ar = imm; m_mem[imm] = m_r[rd]; end
                4'h3: m_r[rd] = m_r[rs];
                4'h4: m_r[rd] = m_r[rd] + m_r[rs];
                4'h5: m_r[rd] = m_r[rd] - m_r[rs];
                4'h6: m_r[rd] = m_r[rd] & m_r[rs];
                4'h7: m_r[rd] = m_r[rd] | m_r[rs];
                4'h8: m_r[rd] = ~m_r[rs];
                4'h9: m_r[rd] = m_r[rd] + 8'd1;
                4'hA: m_r[rd] = m_r[rd] - 8'd1;
                default: ;
            endcase
            if (taken) m_pc = imm;

            @(negedge clk);
            @(negedge clk);
            check("ex0_mem_cs", 16'(mem_cs), 16'h1);
            if (op == 4'h0 || (op >= 4'h3 && op <= 4'hA))
                check("ex0_rd_wr", 16'(rf_r_sel), 16'(hot));
            else
                check("ex0_rf_idle", 16'(rf_r_sel), 16'h0);
            if (op == 4'h1 || op == 4'h2)
                check("ex0_ar_wr", 16'(arf_r_sel), 16'h4);
            else
                check("ex0_arf_wr", 16'(arf_r_sel), taken ? 16'h8 : 16'h0);
            if (op >= 4'h4 && op <= 4'h7) begin
                check("ex0_alu", 16'(alu_fun_sel), 16'(alu_tab[op[1:0]]));
                check("ex0_out_a", 16'(rf_out_a_sel), 16'({1'b0, rd}));
                check("ex0_out_b", 16'(rf_out_b_sel), 16'({1'b0, rs}));
            end

            if (op == 4'hE) begin
                @(negedge clk);
                check("halt_entry", 16'(halted), 16'h1);
                stop = 1'b1;
            end else begin
                if (op == 4'h1 || op == 4'h2) begin
                    @(negedge clk);
                    check("ex1_addr", 16'(arf_out_b_sel), 16'h0);
                    check("ex1_mem_cs", 16'(mem_cs), 16'h0);
                    if (op == 4'h1) begin
                        check("ex1_mux_a", 16'(mux_a_sel), 16'h1);
                        check("ex1_rd_wr", 16'(rf_r_sel), 16'(hot));
                    end else begin
                        check("ex1_mem_wr", 16'(mem_wr), 16'h1);
                    end
                end
                @(negedge clk);
            end
        end

        // reset taken in the middle of an LD
        reset = 1'b1;
        poke(8'h00, 8'h55);
        poke(8'h01, 8'h1C);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("ld_ex0_ar", 16'(arf_r_sel), 16'h4);
        @(negedge clk);
        check("ld_ex1_addr", 16'(arf_out_b_sel), 16'h0);
        check("ld_ex1_cs", 16'(mem_cs), 16'h0);
        check("ld_ex1_mux_a", 16'(mux_a_sel), 16'h1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_arf_fun", 16'(arf_fun_sel), 16'h3);
        check("rst_arf_rsel", 16'(arf_r_sel), 16'hE);
        check("rst_ir_en", 16'(ir_enable), 16'h1);
        check("rst_rf_rsel", 16'(rf_r_sel), 16'hF);
        reset = 1'b0;
        @(negedge clk);
        check("rst_f0_addr", 16'(arf_out_b_sel), 16'h2);
        check("rst_f0_cs", 16'(mem_cs), 16'h0);

        // HALT holds until reset
        reset = 1'b1;
        poke(8'h00, 8'h00);
        poke(8'h01, 8'hE0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            check("halt_flag", 16'(halted), 16'h1);
            check("halt_cs", 16'(mem_cs), 16'h1);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        check("unhalt_flag", 16'(halted), 16'h0);
        check("unhalt_clr", 16'(arf_r_sel), 16'hE);
        reset = 1'b0;
        @(negedge clk);
        check("unhalt_f0", 16'(is_f0()), 16'h1);
        check("unhalt_cs", 16'(mem_cs), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
